// File: rtl/snake_ctrl.sv
// snake_ctrl: game-level controller for the snake body engine.
// Paces movement ticks from video frames, buffers direction presses,
// detects food eating and sequences the game state.
//
// state | meaning
// IDLE  | waiting for start; no ticks, presses ignored
// RUN   | ticks paced from frames, presses queued, eats detected
// LOST  | engine reported a collision; score held until restart
// WON   | engine reached max length; score held until restart
module snake_ctrl #(
    parameter int BASE_FRAMES   = 8,
    parameter int MIN_FRAMES    = 3,
    parameter int SPEEDUP_EVERY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame,
    input  logic [3:0] i_btn,
    input  logic       i_start,
    output logic       o_tick,
    input  logic       i_tick_done,
    output logic [1:0] o_dir,
    input  logic [1:0] i_head_dir,
    input  logic [4:0] i_head_x,
    input  logic [3:0] i_head_y,
    input  logic [4:0] i_food_x,
    input  logic [3:0] i_food_y,
    output logic       o_eat,
    input  logic       i_failure,
    input  logic       i_success,
    output logic       o_restart,
    output logic [1:0] o_state,
    output logic [7:0] o_score
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_LOST = 2'b10,
        ST_WON  = 2'b11
    } state_t;

    localparam logic [7:0] BASE_P  = 8'(BASE_FRAMES);
    localparam logic [7:0] MIN_P   = 8'(MIN_FRAMES);
    localparam logic [7:0] SPEED_N = 8'(SPEEDUP_EVERY);

    state_t     state_q, state_d;
    logic       tick_q, tick_d;
    logic       restart_q, restart_d;
    logic       enter_run, to_idle;
    logic [7:0] frame_cnt_q;
    logic [7:0] period_q;
    logic [7:0] speed_cnt_q;
    logic [7:0] score_q;
    logic       eat_check_q;
    logic [1:0] q0_q, q1_q;
    logic [1:0] q_cnt_q;

    logic       in_run, stay_run, handshake, expire, pop;
    logic       press_one_hot, press_ok;
    logic [1:0] press_dir, ref_dir;
    logic       eat;

    assign in_run    = (state_q == ST_RUN);
    assign stay_run  = in_run && (state_d == ST_RUN);
    assign handshake = tick_q && i_tick_done;
    assign pop       = handshake;
    // >= rather than == so a period shrink while the counter sits at the
    // old terminal value still expires instead of wrapping through 255.
    assign expire    = in_run && i_frame && (frame_cnt_q >= period_q - 8'd1);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // next state, tick request and restart pulse
    always_comb begin
        state_d   = state_q;
        enter_run = 1'b0;
        to_idle   = 1'b0;
        restart_d = 1'b0;
        tick_d    = tick_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d   = ST_RUN;
                    enter_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_failure)      state_d = ST_LOST;
                else if (i_success) state_d = ST_WON;
            end
            default: begin
                if (i_start) begin
                    state_d   = ST_IDLE;
                    to_idle   = 1'b1;
                    restart_d = 1'b1;
                end
            end
        endcase
        if (handshake)          tick_d = 1'b0;
        if (expire)             tick_d = 1'b1;
        if (state_d != ST_RUN)  tick_d = 1'b0;
    end

    // decode a single-button press into a direction code
    always_comb begin
        press_dir     = 2'b00;
        press_one_hot = 1'b0;
        case (i_btn)
            4'b0001: begin press_dir = 2'b00; press_one_hot = 1'b1; end
            4'b0010: begin press_dir = 2'b01; press_one_hot = 1'b1; end
            4'b0100: begin press_dir = 2'b10; press_one_hot = 1'b1; end
            4'b1000: begin press_dir = 2'b11; press_one_hot = 1'b1; end
            default: ;
        endcase
    end

    // presses are judged against the last direction the snake will take
    assign ref_dir  = (q_cnt_q == 2'd0) ? i_head_dir :
                      (q_cnt_q == 2'd1) ? q0_q : q1_q;
    assign press_ok = in_run && press_one_hot &&
                      (press_dir != ref_dir) &&
                      (press_dir != {ref_dir[1], ~ref_dir[0]}) &&
                      ((q_cnt_q != 2'd2) || pop);

    // two-entry direction queue; press evaluated before the same-cycle pop
    always_ff @(posedge clk) begin
        if (rst || enter_run || to_idle) begin
            q0_q    <= 2'b00;
            q1_q    <= 2'b00;
            q_cnt_q <= 2'd0;
        end else begin
            case ({pop && (q_cnt_q != 2'd0), press_ok})
                2'b10: begin
                    q0_q    <= q1_q;
                    q_cnt_q <= q_cnt_q - 2'd1;
                end
                2'b01: begin
                    if (q_cnt_q == 2'd0) q0_q <= press_dir;
                    else                 q1_q <= press_dir;
                    q_cnt_q <= q_cnt_q + 2'd1;
                end
                2'b11: begin
                    if (q_cnt_q == 2'd2) begin
                        q0_q <= q1_q;
                        q1_q <= press_dir;
                    end else begin
                        q0_q <= press_dir;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eat = eat_check_q && stay_run &&
                 (i_head_x == i_food_x) && (i_head_y == i_food_y);

    // tick pacing, eat bookkeeping, score and speed-up
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q      <= 1'b0;
            restart_q   <= 1'b0;
            eat_check_q <= 1'b0;
            frame_cnt_q <= 8'd0;
            period_q    <= BASE_P;
            speed_cnt_q <= 8'd0;
            score_q     <= 8'd0;
        end else begin
            tick_q      <= tick_d;
            restart_q   <= restart_d;
            eat_check_q <= handshake;
            if (enter_run)
                frame_cnt_q <= 8'd0;
            else if (in_run && i_frame)
                frame_cnt_q <= expire ? 8'd0 : frame_cnt_q + 8'd1;
            if (to_idle) begin
                score_q     <= 8'd0;
                period_q    <= BASE_P;
                speed_cnt_q <= 8'd0;
            end else if (eat) begin
                if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                if (speed_cnt_q + 8'd1 >= SPEED_N) begin
                    speed_cnt_q <= 8'd0;
                    if (period_q > MIN_P) period_q <= period_q - 8'd1;
                end else begin
                    speed_cnt_q <= speed_cnt_q + 8'd1;
                end
            end
        end
    end

    assign o_tick    = tick_q;
    assign o_dir     = (q_cnt_q != 2'd0) ? q0_q : i_head_dir;
    assign o_eat     = eat;
    assign o_restart = restart_q;
    assign o_state   = state_q;
    assign o_score   = score_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Bench for snake_ctrl: small engine model plus a direction scoreboard.
module tb_snake_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_frame, i_start, i_failure, i_success;
    logic [3:0] i_btn;
    logic       i_tick_done;
    logic       auto_done, manual_done;
    logic [1:0] o_dir, i_head_dir;
    logic [4:0] i_head_x, i_food_x;
    logic [3:0] i_head_y, i_food_y;
    logic       o_tick, o_eat, o_restart;
    logic [1:0] o_state;
    logic [7:0] o_score;
    logic [1:0] eng_dir;

    int n_vec = 0;
    int n_err = 0;
    int ticks = 0;
    int tick_hi = 0;
    int eats = 0;
    logic [1:0] exp_dir_q[$];

    always #5 clk = ~clk;

    assign i_tick_done = auto_done ? o_tick : manual_done;
    assign i_head_dir  = eng_dir;

    snake_ctrl dut (
        .clk(clk), .rst(rst), .i_frame(i_frame), .i_btn(i_btn),
        .i_start(i_start), .o_tick(o_tick), .i_tick_done(i_tick_done),
        .o_dir(o_dir), .i_head_dir(i_head_dir), .i_head_x(i_head_x),
        .i_head_y(i_head_y), .i_food_x(i_food_x), .i_food_y(i_food_y),
        .o_eat(o_eat), .i_failure(i_failure), .i_success(i_success),
        .o_restart(o_restart), .o_state(o_state), .o_score(o_score)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // engine model: head direction follows the accepted tick direction
    always @(posedge clk) begin
        if (rst) eng_dir <= 2'b11;
        else if (o_tick && i_tick_done) eng_dir <= o_dir;
    end

    // output monitor: counts tick/eat cycles, scoreboards tick directions
    always @(negedge clk) begin
        if (!rst) begin
            if (o_tick) tick_hi++;
            if (o_eat)  eats++;
            if (o_tick && i_tick_done) begin
                ticks++;
                if (exp_dir_q.size() == 0)
                    check("tick_unexpected", 32'(o_dir), 32'hFFFF_FFFF);
                else
                    check("tick_dir", 32'(o_dir), 32'(exp_dir_q.pop_front()));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            i_frame = 1'b1; cyc(1);
            i_frame = 1'b0; cyc(1);
        end
    endtask

    task automatic press(input logic [3:0] b);
        i_btn = b; cyc(1);
        i_btn = 4'd0; cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, h0, e0, exp_period;
        rst = 1'b1; i_frame = 0; i_start = 0; i_failure = 0; i_success = 0;
        i_btn = 4'd0; auto_done = 1'b1; manual_done = 1'b0;
        i_head_x = 5'd0; i_head_y = 4'd0; i_food_x = 5'd5; i_food_y = 4'd4;
        cyc(2);
        rst = 1'b0;
        check("rst_state",   32'(o_state),   0);
        check("rst_tick",    32'(o_tick),    0);
        check("rst_eat",     32'(o_eat),     0);
        check("rst_restart", 32'(o_restart), 0);
        check("rst_score",   32'(o_score),   0);
        check("rst_dir",     32'(o_dir),     3);

        // start and first tick after 8 frames
        i_start = 1'b1; cyc(1); i_start = 1'b0;
        check("start_state", 32'(o_state), 1);
        exp_dir_q.push_back(2'b11);
        frames(7);
        check("t1_early", 32'(ticks), 0);
        frames(1); cyc(1);
        check("t1_ticks", 32'(ticks), 1);
        check("t1_hi", 32'(tick_hi), 1);
        check("t1_clear", 32'(o_tick), 0);

        // reversal rejection, queue fill, drop when full
        press(4'b0100);
        check("t2_reject", 32'(o_dir), 3);
        press(4'b0001);
        press(4'b1000);
        press(4'b0010);
        check("t2_head", 32'(o_dir), 0);
        exp_dir_q.push_back(2'b00);
        exp_dir_q.push_back(2'b11);
        exp_dir_q.push_back(2'b11);
        frames(24); cyc(1);
        check("t2_ticks", 32'(ticks), 4);

        // stretched handshake pops exactly once
        press(4'b0001);
        press(4'b0100);
        exp_dir_q.push_back(2'b00);
        exp_dir_q.push_back(2'b10);
        auto_done = 1'b0;
        t0 = tick_hi; h0 = ticks;
        frames(8); cyc(4);
        check("t3_hold_dir", 32'(o_dir), 0);
        check("t3_hold", 32'(o_tick), 1);
        manual_done = 1'b1; cyc(1); manual_done = 1'b0;
        check("t3_clear", 32'(o_tick), 0);
        check("t3_hi", 32'(tick_hi - t0), 6);
        check("t3_pops", 32'(ticks - h0), 1);
        check("t3_next", 32'(o_dir), 2);
        auto_done = 1'b1;
        frames(8); cyc(1);

        // eating, speed-up every 4 eats, floor at MIN_FRAMES
        i_head_x = 5'd5; i_head_y = 4'd4;
        e0 = eats;
        exp_period = 8;
        for (int e = 1; e <= 24; e++) begin
            h0 = ticks;
            exp_dir_q.push_back(2'b10);
            frames(exp_period); cyc(2);
            check("t4_tick", 32'(ticks - h0), 1);
            if (e == 1) begin
                check("t4_score1", 32'(o_score), 1);
                check("t4_eat1", 32'(eats - e0), 1);
            end
            if ((e % 4) == 0 && exp_period > 3) exp_period--;
        end
        check("t4_score", 32'(o_score), 24);
        check("t4_eats", 32'(eats - e0), 24);
        h0 = ticks;
        frames(2); cyc(1);
        check("t4_floor_early", 32'(ticks - h0), 0);
        exp_dir_q.push_back(2'b10);
        frames(1); cyc(2);
        check("t4_floor", 32'(ticks - h0), 1);
        check("t4_score25", 32'(o_score), 25);
        i_head_x = 5'd0; i_head_y = 4'd0;

        // failure and success together -> LOST, then restart
        i_failure = 1'b1; i_success = 1'b1; cyc(1);
        i_failure = 1'b0; i_success = 1'b0;
        check("t5_lost", 32'(o_state), 2);
        h0 = ticks;
        frames(10);
        check("t5_noticks", 32'(ticks - h0), 0);
        check("t5_hold", 32'(o_score), 25);
        i_start = 1'b1; cyc(1); i_start = 1'b0;
        check("t5_restart", 32'(o_restart), 1);
        check("t5_idle", 32'(o_state), 0);
        check("t5_score0", 32'(o_score), 0);
        cyc(1);
        check("t5_pulse", 32'(o_restart), 0);

        // reset while a tick is pending and the queue is full
        i_start = 1'b1; cyc(1); i_start = 1'b0;
        press(4'b0001);
        press(4'b1000);
        auto_done = 1'b0;
        frames(8);
        check("t6_pending", 32'(o_tick), 1);
        rst = 1'b1; cyc(1);
        check("t6_tick", 32'(o_tick), 0);
        check("t6_state", 32'(o_state), 0);
        check("t6_eat", 32'(o_eat), 0);
        check("t6_restart", 32'(o_restart), 0);
        check("t6_score", 32'(o_score), 0);
        check("t6_qempty", 32'(o_dir), 3);
        rst = 1'b0; auto_done = 1'b1;
        cyc(1);

        check("sb_empty", 32'(exp_dir_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/snake_ctrl.md
Name: snake_ctrl

Overview:
- Game controller that drives the snake body engine's tick/direction handshake and consumes its status outputs (head position, head direction, failure, success).
- Paces movement from frame pulses, buffers player direction presses with reversal rejection, and detects food eating.
- Generates the one-cycle eat pulse that grows the snake, and runs the top-level game state machine.

Parameters:
- BASE_FRAMES, 8, initial frames per movement tick (2..255).
- MIN_FRAMES, 3, fastest allowed frames per tick (1..BASE_FRAMES).
- SPEEDUP_EVERY, 4, number of eats between one-frame period reductions (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_frame  in  1  one-cycle pulse per video frame.
- i_btn  in  4  debounced press pulses: bit0 up, bit1 down, bit2 left, bit3 right.
- i_start  in  1  start/restart request pulse.
- o_tick  out  1  movement request to snake engine.
- i_tick_done  in  1  engine accepted tick (same cycle as o_tick high).
- o_dir  out  2  direction for the tick: 00 up, 01 down, 10 left, 11 right.
- i_head_dir  in  2  engine's current head direction.
- i_head_x  in  5  engine head x.
- i_head_y  in  4  engine head y.
- i_food_x  in  5  food x.
- i_food_y  in  4  food y.
- o_eat  out  1  one-cycle grow pulse to engine; also the food regeneration request.
- i_failure  in  1  engine collision flag.
- i_success  in  1  engine max-length flag.
- o_restart  out  1  one-cycle pulse; top level uses it to reset the engine.
- o_state  out  2  00 IDLE, 01 RUN, 10 LOST, 11 WON.
- o_score  out  8  eats this game, saturating at 255.

Behaviour:
- Reset values:
  - state IDLE; o_tick 0; o_eat 0; o_restart 0; o_score 0.
  - Queue empty; frame counter 0; period BASE_FRAMES; speedup counter 0; eat-check flag 0.
  - Reset mid-tick drops o_tick in the next cycle.
- State IDLE:
  - No ticks; presses ignored.
  - i_start -> RUN. On entry: clear frame counter and queue.
- State RUN, frame counter:
  - Increments on i_frame.
  - When the counter equals period-1 and i_frame is high: counter goes to 0 and o_tick is set next cycle.
- State RUN, tick handshake:
  - o_tick holds high until a cycle with i_tick_done=1, then clears next cycle.
  - Frame pulses while o_tick is pending still count; a second expiry while pending is not queued.
- o_dir (combinational):
  - Queue head when the queue is non-empty, else i_head_dir.
  - The queue pops in the i_tick_done cycle.
- Direction queue, 2 entries:
  - A press is accepted only in RUN and only when exactly one i_btn bit is set; multi-bit presses are ignored.
  - Reference direction is the last queued entry if the queue is non-empty, else i_head_dir.
  - Reject the press if it equals the reference or the reference with lsb flipped (reversal).
  - Drop the press if the queue is full.
  - Press and pop in the same cycle: evaluate the press against the pre-pop contents, then pop. A press into a full queue in a pop cycle is accepted.
- Eat detection:
  - The eat-check flag is registered from i_tick_done, so it is high the cycle after the handshake, when the engine head has updated.
  - o_eat = eat_check AND head==food, combinational, exactly one cycle.
  - On o_eat: score increments (saturating at 255) and the speedup counter increments.
  - When the speedup counter reaches SPEEDUP_EVERY: it clears, and period decrements if period > MIN_FRAMES.
  - Eat is suppressed if state leaves RUN in the same cycle.
- Failure and success:
  - i_failure sampled in any RUN cycle -> LOST.
  - Otherwise i_success -> WON.
  - Both high in the same cycle -> LOST.
  - On exit from RUN, o_tick is cleared next cycle.
- States LOST and WON:
  - Hold score; no ticks.
  - i_start -> o_restart pulse next cycle, then IDLE.
  - Score, period, speedup counter and queue clear on that transition.
- Widths:
  - Frame counter 8 bits, compared against period-1.
  - Period 8 bits.

Test Plan:
- Reset, i_start, 8 frame pulses with i_tick_done tied to o_tick -> exactly one tick (o_tick high 1 cycle) after the 8th frame, o_dir=i_head_dir=11.
- i_head_dir=11: press left (bit2) -> rejected; press up then right -> queue [00,11]; next two ticks give o_dir 00 then 11; a third press while full is dropped.
- Hold i_tick_done low for 5 cycles after o_tick -> o_tick stays high 5 cycles, clears the cycle after i_tick_done; the queue pops once.
- Head (5,4) = food (5,4) the cycle after handshake -> o_eat for 1 cycle, score 1; after 4 eats the period is 7 frames; it floors at MIN_FRAMES=3 after 20 eats.
- i_failure and i_success asserted together in RUN -> o_state=10, no further ticks; i_start -> o_restart pulse, o_state=00, score 0.
- Assert rst while o_tick is pending and the queue is full -> all outputs at reset values the next cycle; the queue is empty.
